cas_tone_gen: RTL
=================

# cas_tone_gen

Cassette FSK tone generator: takes bytes over a valid/ready stream and produces the square-wave tape signal that the serial ULA's cassette data separator expects on CasIn.
- Frame: start bit, 8 data bits LSB first, one stop bit.
- Tones: 1200 Hz for 0, 2400 Hz for 1. Leader and idle time is filled with high tone.
- Use: playback/tape-emulation source on the board and stimulus source in system simulation.
- Runs on the same 16/13 MHz clock as the ULA, so one 1200-baud bit is 1024 clocks.

## Interface
- BIT_LOG2, default 10: log2 of clocks per bit (10 → 1024 clk = 832 µs at 16/13 MHz); must be ≥ 3.
- LEADER_BITS, default 16: number of high-tone bits emitted after motor-on before the first frame; range 1..8191, counter is 13 bits.
- clk  input  1  fast clock (16/13 MHz), all logic on posedge.
- nRST  input  1  asynchronous active-low reset.
- motor  input  1  level, synchronous to clk; 1 = tape running.
- in_data  input  8  byte to send.
- in_valid  input  1  in_data valid.
- in_ready  output  1  holding buffer empty; byte accepted on clk edge where in_valid && in_ready.
- cas_out  output  1  FSK square wave (drives CasIn).
- busy  output  1  a frame (start..stop) is being emitted.
- frame_done  output  1  one-cycle pulse at end of each stop bit.

## Operation
- **Reset values:** state OFF, phase 0, leader count 0, hold buffer empty, cas_out 0, in_ready 1, busy 0, frame_done 0.
- **Bit timer:** phase counter, BIT_LOG2 bits, free-running while state ≠ OFF. The bit boundary is phase == all-ones. Wrap-around to 0 starts the next bit.
- **Tone encoding:**
  - Bit value b, P = phase.
  - 0-bit: cas_out = P[BIT_LOG2-1], one 1200 Hz cycle.
  - 1-bit: cas_out = P[BIT_LOG2-2], two 2400 Hz cycles.
  - Every bit starts low and ends high, so a falling edge always marks the bit boundary.
- **Holding buffer:** one byte.
  - in_ready = !hold_valid.
  - Accept sets hold_valid.
  - Transfer to the shifter at a bit boundary clears hold_valid.
- **State OFF:** cas_out 0, phase held at 0. motor 1 → LEADER with leader count 0.
- **State LEADER:** emits 1-bits. At each boundary the leader count increments. After bit LEADER_BITS completes:
  - if hold_valid: load the shifter and go to DATA;
  - otherwise go to IDLE.
- **State IDLE:** emits 1-bits. At a boundary with hold_valid: load the shifter and go to DATA.
- **State DATA:** bit index 0..9. Index 0 = 0 (start), 1..8 = data[0..7], 9 = 1 (stop).
  - At the end of index 9, frame_done pulses.
  - If hold_valid: reload and stay in DATA, back-to-back with no gap.
  - Otherwise go to IDLE.
  - busy = (state == DATA).
- **motor falling, any state, any phase:** next cycle goes to OFF, phase 0, cas_out 0, busy 0. The in-flight frame is abandoned with no frame_done. The holding buffer is kept and sent after the next leader.
- **Simultaneous events:**
  - Accept in the same cycle as a boundary: the new byte is not visible to that boundary and is loaded at the next one.
  - motor falling at a boundary: OFF takes priority; no load, no frame_done.
- **in_valid while OFF:** still accepted into the holding buffer if it is empty.

## Timing
- cas_out is registered: it reflects state/phase of the previous cycle (1-cycle latency from phase).
- First cas_out edge after motor rises: rising edge at clk 2^(BIT_LOG2-2)+1 after motor sampled high.
- Byte accept to first start-bit clock:
  - from IDLE: ≤ 2^BIT_LOG2 + 1 clk;
  - from DATA: up to 10·2^BIT_LOG2 clk.
- Frame length: exactly 10·2^BIT_LOG2 clk. Back-to-back frames have no gap.
- frame_done is asserted in the cycle the stop bit's last phase is registered.
- in_ready rises the cycle after the shifter load.
- Sustained throughput: one byte per 10 bit periods.

## Configuration
- CAS_TONE_GEN_LEADER_EN:
  - Defined: LEADER state and LEADER_BITS behave as above.
  - Undefined: motor rising goes directly to IDLE. The first frame may start at the first bit boundary. The leader counter is not built and LEADER_BITS is ignored.

## Test plan
- **Reset mid-frame:** assert nRST low during DATA index 4 → all outputs return to reset values immediately; after release, with motor 1, the leader restarts.
- **Leader, default config, macro defined:** motor 1 with no data → 16 bits of 2400 Hz: cas_out toggles every 256 clk, 64 edges in 16384 clk. Then IDLE continues the same tone.
- **Single byte 0xA5 after leader:** cas_out period sequence 1024 (start), then 512-cycle pairs for 1, 1024 for 0, LSB first: 1,0,1,0,0,1,0,1. Stop bit = two 512-cycle periods. frame_done pulses once. Then high tone resumes.
- **Back-to-back bytes:** offer 0x00 and 0xFF with in_valid held → second start bit begins on the clock after the first stop bit ends; in_ready low while the buffer is full.
- **Motor drop mid-frame:** motor 0 at DATA index 5 → next cycle cas_out 0, busy 0, no frame_done, buffered byte retained. Motor 1 again → 16 leader bits, then the buffered byte is sent.
- **Macro undefined:** motor 1 with a byte already buffered → start bit begins at the first bit boundary (clk 1024); no leader.

Source files
------------

// File: rtl/cas_tone_gen.sv
// ---------------------------------------------------------------------------
// cas_tone_gen
//
// Cassette FSK tone generator. Bytes arrive on a valid/ready stream, pass
// through a one-byte holding buffer and are sent as 10-bit frames
// (start 0, eight data bits LSB first, stop 1). A 0-bit is one cycle of
// the low tone and a 1-bit is two cycles of the high tone, both derived
// from the bit-phase counter. Leader and idle time are filled with 1-bits.
// Every bit starts low and ends high, so a falling edge always marks a
// bit boundary.
//
// Parameters:
//   BIT_LOG2     log2 of clocks per bit (>= 3)
//   LEADER_BITS  high-tone bits after motor-on before the first frame
//                (1..8191), only used when the leader is built
//
// Configuration macro:
//   CAS_TONE_GEN_LEADER_EN  defined   : motor-on emits LEADER_BITS leader bits
//                           undefined : motor-on goes straight to idle tone
//
// Ports:
//   clk         fast clock, all logic on posedge
//   nRST        asynchronous active-low reset
//   motor       tape running level, synchronous to clk
//   in_data     byte to send
//   in_valid    in_data valid
//   in_ready    holding buffer empty; accept on in_valid && in_ready
//   cas_out     registered FSK square wave
//   busy        a frame (start..stop) is being emitted
//   frame_done  one-cycle pulse at the end of each stop bit
// ---------------------------------------------------------------------------
module cas_tone_gen #(
  parameter int BIT_LOG2    = 10,
  parameter int LEADER_BITS = 16
) (
  input  logic       clk,
  input  logic       nRST,
  input  logic       motor,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       cas_out,
  output logic       busy,
  output logic       frame_done
);

  // Elaboration-time parameter sanity checks.
  if (BIT_LOG2 < 3) begin : g_bad_bit_log2
    $error("cas_tone_gen: BIT_LOG2 must be >= 3");
  end
  if (LEADER_BITS < 1 || LEADER_BITS > 8191) begin : g_bad_leader_bits
    $error("cas_tone_gen: LEADER_BITS must be in 1..8191");
  end

  typedef enum logic [1:0] {
    ST_OFF,
    ST_LEADER,
    ST_IDLE,
    ST_DATA
  } state_t;

  localparam logic [BIT_LOG2-1:0] PHASE_ONE = {{(BIT_LOG2-1){1'b0}}, 1'b1};

`ifdef CAS_TONE_GEN_LEADER_EN
  localparam state_t ON_STATE = ST_LEADER;
`else
  localparam state_t ON_STATE = ST_IDLE;
`endif

  state_t              state;
  state_t              state_next;
  logic [BIT_LOG2-1:0] phase;
  logic [BIT_LOG2-1:0] phase_next;
  logic                hold_valid;
  logic [7:0]          hold_data;
  logic [9:0]          shifter;
  logic [9:0]          shifter_next;
  logic [3:0]          bit_idx;
  logic [3:0]          bit_idx_next;
  logic                boundary;
  logic                accept;
  logic                load;
  logic                leader_last;
  logic                tone_bit;
  logic                tone;
  logic                cas_next;
  logic                done_next;

  assign boundary = (state != ST_OFF) && (phase == '1);
  assign accept   = in_valid && !hold_valid;

  // Leader bit counter; only the last leader boundary matters to the FSM.
`ifdef CAS_TONE_GEN_LEADER_EN
  logic [12:0] leader_cnt;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      leader_cnt <= '0;
    end else if (state == ST_OFF) begin
      leader_cnt <= '0;
    end else if (state == ST_LEADER && boundary) begin
      leader_cnt <= leader_cnt + 13'd1;
    end
  end

  assign leader_last = (leader_cnt == 13'(LEADER_BITS - 1));
`else
  assign leader_last = 1'b1;
`endif

  // State register.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state <= ST_OFF;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. Motor low wins over any boundary action; a load
  // happens only at a boundary with a byte already waiting.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      ST_OFF: begin
        if (motor) state_next = ON_STATE;
      end
      ST_LEADER: begin
        if (!motor) begin
          state_next = ST_OFF;
        end else if (boundary && leader_last) begin
          if (hold_valid) begin
            load       = 1'b1;
            state_next = ST_DATA;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      ST_IDLE: begin
        if (!motor) begin
          state_next = ST_OFF;
        end else if (boundary && hold_valid) begin
          load       = 1'b1;
          state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (!motor) begin
          state_next = ST_OFF;
        end else if (boundary && bit_idx == 4'd9) begin
          if (hold_valid) begin
            load = 1'b1;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_OFF;
    endcase
  end

  // Datapath next values: phase runs only while the tape is on, the
  // shifter presents the current frame bit in bit 0.
  always_comb begin
    phase_next   = phase + PHASE_ONE;
    shifter_next = shifter;
    bit_idx_next = bit_idx;
    if (state == ST_OFF || state_next == ST_OFF) begin
      phase_next = '0;
    end
    if (load) begin
      shifter_next = {1'b1, hold_data, 1'b0};
      bit_idx_next = 4'd0;
    end else if (state == ST_DATA && boundary && motor) begin
      shifter_next = {1'b1, shifter[9:1]};
      bit_idx_next = bit_idx + 4'd1;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      phase      <= '0;
      hold_valid <= 1'b0;
      hold_data  <= '0;
      shifter    <= '0;
      bit_idx    <= '0;
      cas_out    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      phase      <= phase_next;
      shifter    <= shifter_next;
      bit_idx    <= bit_idx_next;
      cas_out    <= cas_next;
      frame_done <= done_next;
      if (accept) begin
        hold_valid <= 1'b1;
        hold_data  <= in_data;
      end else if (load) begin
        hold_valid <= 1'b0;
      end
    end
  end

  // Output logic. Leader and idle send 1-bits; the low tone uses the phase
  // MSB and the high tone the next bit down, so both end high.
  always_comb begin
    tone_bit  = (state == ST_DATA) ? shifter[0] : 1'b1;
    tone      = tone_bit ? phase[BIT_LOG2-2] : phase[BIT_LOG2-1];
    cas_next  = (state != ST_OFF) && motor && tone;
    done_next = (state == ST_DATA) && motor && boundary && (bit_idx == 4'd9);
    busy      = (state == ST_DATA);
    in_ready  = !hold_valid;
  end

endmodule
